mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter between the instruction cache and the data cache. It takes the two caches' request/handshake signals, grants one requester at a time to the single RAM port and returns data and wait status to each side. Data requests win by default. A bounded starvation counter guarantees instruction fetches make progress.

## Interface
Parameters:
- WORD_W, 32, width of addresses and data words (word_t).
- STARVE_LIMIT, 4, consecutive data grants allowed while an instruction request is pending; range 1..15.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; **one clock; reset is synchronous and active-high.**
- iREN  in  1  icache read request.
- iaddr  in  WORD_W  icache word address.
- iload  out  WORD_W  instruction read data.
- iwait  out  1  low exactly in the cycle the icache request completes.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  WORD_W  dcache word address.
- dstore  in  WORD_W  dcache write data.
- dload  out  WORD_W  data read data.
- dwait  out  1  low exactly in the cycle the dcache request completes.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

## Operation
- **FSM states:** IDLE, DGRANT, IGRANT. The state and starve_cnt (4 bits) are registered.
- **IDLE:**
  - No RAM enables are driven; iwait=dwait=1.
  - Arbitration picks a requester as follows:
    - if (dREN|dWEN) and not (iREN and starve_cnt==STARVE_LIMIT), go to DGRANT;
    - else if iREN, go to IGRANT;
    - else stay in IDLE.
- **DGRANT:**
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN, and ramREN=dREN&~dWEN. When both dREN and dWEN are high, the request is treated as a write.
  - dwait = (ramstate!=ACCESS); iwait=1.
- **IGRANT:**
  - ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
  - iwait = (ramstate!=ACCESS); dwait=1.
- **Completion:** when ramstate==ACCESS in a grant state, the grant ends and the next state is IDLE.
- **RAM status handling:**
  - BUSY and FREE hold the grant.
  - ERROR is not a completion: the grant and RAM enables are held and the access is retried until ACCESS.
- **Abort:** if the granted requester drops its request while in a grant state (DGRANT with dREN=dWEN=0, or IGRANT with iREN=0), the grant ends and the next state is IDLE. RAM enables drop combinationally in that cycle.
- **Starvation counter:**
  - On entry to DGRANT while iREN=1, starve_cnt increments, saturating at STARVE_LIMIT.
  - On entry to IGRANT, or whenever iREN=0 in IDLE, starve_cnt clears to 0.
- **Read data:** iload=ramload and dload=ramload at all times (combinational pass-through). Data is valid only in the cycle where the corresponding wait is low.
- **Outputs in IDLE:** ramaddr=0 and ramstore=0.

## Timing
- **Reset:** state=IDLE, starve_cnt=0. While RST=1, outputs are iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- **Reset mid-transfer:** asserting RST during a grant forces IDLE at the next edge. RAM enables are low in every cycle in which RST=1.
- **Request stability:** the caches hold address, data and enables stable from assertion until their wait is low. The arbiter does not latch request contents.
- **Latency (RAM returns ACCESS on its k-th granted cycle):**
  - a request first seen in IDLE at cycle t drives the RAM from cycle t+1;
  - wait is low at cycle t+k;
  - the next arbitration happens at t+k+1.
- **Minimum spacing:** back-to-back accesses are at least k+1 cycles apart; there is one IDLE bubble per access.
- **Simultaneous requests:** when iREN and dREN arrive in the same IDLE cycle, data is served first unless starve_cnt==STARVE_LIMIT.
- **Wait outputs:** iwait and dwait are never low in the same cycle, and never low in IDLE.

## Test plan
- **Reset:** hold RST=1 for 3 cycles with iREN=dREN=1 -> iwait=dwait=1 and ramREN=ramWEN=0 throughout. After release, DGRANT is entered one cycle later.
- **Single read:**
  - Stimulus: iREN=1, iaddr=0x0000_0040; RAM model with ramstate BUSY,BUSY,ACCESS and ramload=0xDEAD_BEEF.
  - Response: ramREN=1 and ramaddr=0x40 from cycle 1. iwait=0 and iload=0xDEAD_BEEF exactly in cycle 3. IDLE in cycle 4.
- **Contention:** iREN=1 and dWEN=1 (daddr=0x80, dstore=0x1234_5678) raised together -> RAM write to 0x80 with 0x12345678 completes first (dwait low). The instruction read follows after one IDLE cycle.
- **Starvation (STARVE_LIMIT=4):** iREN held high while dREN is re-requested immediately after each completion -> exactly 4 data grants, then an IGRANT, then starve_cnt=0.
- **ERROR retry:** ramstate sequence ERROR,ERROR,ACCESS during a dcache read -> the grant and ramREN are held for 3 cycles, and dwait is low only in the ACCESS cycle.
- **Abort:** dcache drops dREN mid-grant, and RST=1 mid-grant in a separate run -> RAM enables drop immediately. Return to IDLE, with no wait pulse emitted.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the instruction and data caches.
// Data requests win unless an instruction fetch has been passed over STARVE_LIMIT times.
module mem_arbiter #(
  parameter int WORD_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic [WORD_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic [WORD_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_e;

  state_e     state_q, state_d;
  logic [3:0] starveCnt_q, starveCnt_d;
  logic       dReq;
  logic       ramDone;

  assign dReq    = dREN | dWEN;
  assign ramDone = (ramstate == RAM_ACCESS);
  assign iload   = ramload;
  assign dload   = ramload;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      starveCnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      starveCnt_q <= starveCnt_d;
    end
  end

  // Waits only fall on ACCESS while the request is still held, so an abort never pulses a wait.
  always_comb begin
    state_d     = state_q;
    starveCnt_d = starveCnt_q;
    iwait       = 1'b1;
    dwait       = 1'b1;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    case (state_q)
      IDLE: begin
        if (!iREN) starveCnt_d = 4'd0;
        if (dReq && !(iREN && starveCnt_q == LIMIT)) begin
          state_d = DGRANT;
          if (iREN && starveCnt_q < LIMIT) starveCnt_d = starveCnt_q + 4'd1;
        end else if (iREN) begin
          state_d     = IGRANT;
          starveCnt_d = 4'd0;
        end
      end
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = ~(dReq & ramDone);
        if (!dReq || ramDone) state_d = IDLE;
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iwait   = ~(iREN & ramDone);
        if (!iREN || ramDone) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (RST) begin
      state_d     = IDLE;
      starveCnt_d = 4'd0;
      iwait       = 1'b1;
      dwait       = 1'b1;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle output checks plus a read-data scoreboard
// filled when a completing cycle is driven and drained when a wait falls.
module tb_mem_arbiter;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic        CLK, RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb[$];

  mem_arbiter #(.WORD_W(32), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change 1 time unit after the rising edge and are checked 1 unit later.
  task automatic applyStimulus(input logic rst, input logic irn, input logic [31:0] ia,
                               input logic drn, input logic dwn, input logic [31:0] da,
                               input logic [31:0] ds, input logic [1:0] rs,
                               input logic [31:0] rl);
    @(posedge CLK);
    #1;
    RST = rst; iREN = irn; iaddr = ia; dREN = drn; dWEN = dwn;
    daddr = da; dstore = ds; ramstate = rs; ramload = rl;
    #1;
  endtask

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic eIwait, input logic eDwait,
                             input logic eRen, input logic eWen,
                             input logic [31:0] eAddr, input logic [31:0] eStore);
    logic [31:0] expData;
    compare({tag, ".iwait"}, 32'(iwait), 32'(eIwait));
    compare({tag, ".dwait"}, 32'(dwait), 32'(eDwait));
    compare({tag, ".ramREN"}, 32'(ramREN), 32'(eRen));
    compare({tag, ".ramWEN"}, 32'(ramWEN), 32'(eWen));
    compare({tag, ".ramaddr"}, ramaddr, eAddr);
    compare({tag, ".ramstore"}, ramstore, eStore);
    if (iwait === 1'b0 || dwait === 1'b0) begin
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("[TB] FAIL %s.unexpected_wait: observed iwait=%b dwait=%b expected no completion",
               tag, iwait, dwait);
      end
      if (sb.size() != 0) begin
        expData = sb.pop_front();
        compare({tag, ".load"}, (iwait === 1'b0) ? iload : dload, expData);
      end
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput(tag, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

    // Reset held with both requests pending.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1, 1, 32'h0, 1, 0, 32'h100, 32'h0, FREE, 32'h0);
      checkIdle("reset");
    end
    applyStimulus(0, 1, 32'h0, 1, 0, 32'h100, 32'h0, FREE, 32'h0);
    checkIdle("post_reset_idle");
    applyStimulus(0, 1, 32'h0, 1, 0, 32'h100, 32'h0, FREE, 32'h0);
    checkOutput("post_reset_dgrant", 1, 1, 1, 0, 32'h100, 32'h0);
    sb.push_back(32'hA5A5_0001);
    applyStimulus(0, 1, 32'h0, 1, 0, 32'h100, 32'h0, ACCESS, 32'hA5A5_0001);
    checkOutput("post_reset_done", 1, 0, 1, 0, 32'h100, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, FREE, 32'h0);
    checkIdle("post_reset_back");

    // Single instruction read, ACCESS on the third granted cycle.
    applyStimulus(0, 1, 32'h40, 0, 0, 32'h0, 32'h0, FREE, 32'h0);
    checkIdle("iread_c0");
    applyStimulus(0, 1, 32'h40, 0, 0, 32'h0, 32'h0, BUSY, 32'h0);
    checkOutput("iread_c1", 1, 1, 1, 0, 32'h40, 32'h0);
    applyStimulus(0, 1, 32'h40, 0, 0, 32'h0, 32'h0, BUSY, 32'h0);
    checkOutput("iread_c2", 1, 1, 1, 0, 32'h40, 32'h0);
    sb.push_back(32'hDEAD_BEEF);
    applyStimulus(0, 1, 32'h40, 0, 0, 32'h0, 32'h0, ACCESS, 32'hDEAD_BEEF);
    checkOutput("iread_c3", 0, 1, 1, 0, 32'h40, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, FREE, 32'h0);
    checkIdle("iread_c4");

    // Simultaneous instruction read and data write: the write goes first.
    applyStimulus(0, 1, 32'h44, 0, 1, 32'h80, 32'h1234_5678, FREE, 32'h0);
    checkIdle("cont_c0");
    applyStimulus(0, 1, 32'h44, 0, 1, 32'h80, 32'h1234_5678, FREE, 32'h0);
    checkOutput("cont_write", 1, 1, 0, 1, 32'h80, 32'h1234_5678);
    sb.push_back(32'h0000_0000);
    applyStimulus(0, 1, 32'h44, 0, 1, 32'h80, 32'h1234_5678, ACCESS, 32'h0);
    checkOutput("cont_write_done", 1, 0, 0, 1, 32'h80, 32'h1234_5678);
    applyStimulus(0, 1, 32'h44, 0, 0, 32'h0, 32'h0, FREE, 32'h0);
    checkIdle("cont_bubble");
    sb.push_back(32'h0BAD_F00D);
    applyStimulus(0, 1, 32'h44, 0, 0, 32'h0, 32'h0, ACCESS, 32'h0BAD_F00D);
    checkOutput("cont_iread_done", 0, 1, 1, 0, 32'h44, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, FREE, 32'h0);
    checkIdle("cont_end");

    // Starvation: four data grants while iREN stays high, then the fetch wins.
    for (int g = 0; g < 4; g++) begin
      applyStimulus(0, 1, 32'h48, 1, 0, 32'h200, 32'h0, FREE, 32'h0);
      checkIdle($sformatf("starve_idle%0d", g));
      sb.push_back(32'h1000 + 32'(g));
      applyStimulus(0, 1, 32'h48, 1, 0, 32'h200, 32'h0, ACCESS, 32'h1000 + 32'(g));
      checkOutput($sformatf("starve_dgrant%0d", g), 1, 0, 1, 0, 32'h200, 32'h0);
    end
    applyStimulus(0, 1, 32'h48, 1, 0, 32'h200, 32'h0, FREE, 32'h0);
    checkIdle("starve_idle4");
    compare("starve_cnt_sat", 32'(dut.starveCnt_q), 32'd4);
    sb.push_back(32'h2222_2222);
    applyStimulus(0, 1, 32'h48, 1, 0, 32'h200, 32'h0, ACCESS, 32'h2222_2222);
    checkOutput("starve_igrant", 0, 1, 1, 0, 32'h48, 32'h0);
    compare("starve_cnt_clr", 32'(dut.starveCnt_q), 32'd0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, FREE, 32'h0);
    checkIdle("starve_end");

    // ERROR is retried with the grant held.
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h300, 32'h0, FREE, 32'h0);
    checkIdle("err_c0");
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h300, 32'h0, ERROR, 32'hFFFF_FFFF);
    checkOutput("err_c1", 1, 1, 1, 0, 32'h300, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h300, 32'h0, ERROR, 32'hFFFF_FFFF);
    checkOutput("err_c2", 1, 1, 1, 0, 32'h300, 32'h0);
    sb.push_back(32'h3333_3333);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h300, 32'h0, ACCESS, 32'h3333_3333);
    checkOutput("err_c3", 1, 0, 1, 0, 32'h300, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, FREE, 32'h0);
    checkIdle("err_end");

    // Data cache drops its request mid-grant while the RAM reports ACCESS.
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h400, 32'h0, FREE, 32'h0);
    checkIdle("abort_c0");
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h400, 32'h0, BUSY, 32'h0);
    checkOutput("abort_c1", 1, 1, 1, 0, 32'h400, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h400, 32'h0, ACCESS, 32'h0);
    checkOutput("abort_drop", 1, 1, 0, 0, 32'h400, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h400, 32'h0, ACCESS, 32'h0);
    checkIdle("abort_idle");

    // Reset asserted during an instruction grant.
    applyStimulus(0, 1, 32'h60, 0, 0, 32'h0, 32'h0, FREE, 32'h0);
    checkIdle("rstmid_c0");
    applyStimulus(0, 1, 32'h60, 0, 0, 32'h0, 32'h0, BUSY, 32'h0);
    checkOutput("rstmid_c1", 1, 1, 1, 0, 32'h60, 32'h0);
    applyStimulus(1, 1, 32'h60, 0, 0, 32'h0, 32'h0, ACCESS, 32'h0);
    checkIdle("rstmid_rst");
    applyStimulus(0, 0, 32'h60, 0, 0, 32'h0, 32'h0, ACCESS, 32'h0);
    checkIdle("rstmid_idle");

    compare("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
